// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a programmed number of unsigned 16-bit products behind valid/ready handshakes with a sticky carry flag
module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic [ACC_W:0] sum;
  logic beat, go;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign acc_out   = acc;
  assign beat      = in_ready && in_valid;
  assign go        = state == IDLE && start;
  assign sum       = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = start ? (len == '0 ? DONE : ACCUM) : IDLE;
    else if (state == ACCUM) state_nxt = (beat && count == LEN_W'(1)) ? DONE : ACCUM;
    else if (state == DONE) state_nxt = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        acc   <= '0;
        ovf   <= 1'b0;
        count <= len;
      end else if (beat) begin
        acc   <= sum[ACC_W-1:0];
        ovf   <= ovf | sum[ACC_W];
        count <= count - LEN_W'(1);
      end
    end
  end
endmodule
